// File: rtl/cmd_proc.sv
// cmd_proc: command processor behind a UART wrapper.
// Takes 16-bit commands, runs NOP/CAL/MOVE/WRITE/READ, returns a one-byte response.
module cmd_proc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rdy,
  input  logic [15:0] cmd,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic [7:0]  resp,
  input  logic        resp_sent,
  output logic        strt_cal,
  input  logic        cal_done,
  input  logic        sq_done,
  output logic        moving,
  output logic [7:0]  heading,
  output logic        busy
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_CAL   = 4'h2;
  localparam logic [3:0] OP_MOVE  = 4'h4;
  localparam logic [3:0] OP_WRITE = 4'h8;
  localparam logic [3:0] OP_READ  = 4'h9;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    CAL,
    MOVE,
    RESP,
    WAIT_SENT
  } state_t;

  state_t      state;
  logic [15:0] cmd_q;
  logic [3:0]  sq_cnt;
  logic [7:0]  regs [4];

  logic [3:0]  opcode;
  logic [1:0]  addr;

  assign opcode = cmd_q[15:12];
  assign addr   = cmd_q[9:8];

  // The acknowledge must reach the wrapper in the same cycle the command is taken.
  assign clr_cmd_rdy = (state == IDLE) && cmd_rdy;
  assign busy        = (state != IDLE);

  // Register file: only WRITE in EXEC modifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 8'h00;
      end
    end else if ((state == EXEC) && (opcode == OP_WRITE)) begin
      regs[addr] <= cmd_q[7:0];
    end
  end

  // Main controller; pulses are set on the transition into their state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_q     <= 16'h0000;
      resp      <= 8'h00;
      heading   <= 8'h00;
      sq_cnt    <= 4'h0;
      send_resp <= 1'b0;
      strt_cal  <= 1'b0;
      moving    <= 1'b0;
    end else begin
      send_resp <= 1'b0;
      strt_cal  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_rdy) begin
            cmd_q <= cmd;
            state <= EXEC;
          end
        end
        EXEC: begin
          case (opcode)
            OP_NOP, OP_WRITE: begin
              resp      <= RESP_ACK;
              send_resp <= 1'b1;
              state     <= RESP;
            end
            OP_READ: begin
              resp      <= regs[addr];
              send_resp <= 1'b1;
              state     <= RESP;
            end
            OP_CAL: begin
              strt_cal <= 1'b1;
              state    <= CAL;
            end
            OP_MOVE: begin
              heading <= cmd_q[11:4];
              sq_cnt  <= cmd_q[3:0];
              if (cmd_q[3:0] == 4'h0) begin
                resp      <= RESP_ACK;
                send_resp <= 1'b1;
                state     <= RESP;
              end else begin
                moving <= 1'b1;
                state  <= MOVE;
              end
            end
            default: begin
              resp      <= RESP_NAK;
              send_resp <= 1'b1;
              state     <= RESP;
            end
          endcase
        end
        CAL: begin
          if (cal_done) begin
            resp      <= RESP_ACK;
            send_resp <= 1'b1;
            state     <= RESP;
          end
        end
        MOVE: begin
          if (sq_done) begin
            sq_cnt <= sq_cnt - 4'h1;
            if (sq_cnt == 4'h1) begin
              moving    <= 1'b0;
              resp      <= RESP_ACK;
              send_resp <= 1'b1;
              state     <= RESP;
            end
          end
        end
        RESP: begin
          state <= WAIT_SENT;
        end
        WAIT_SENT: begin
          if (resp_sent) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_proc.sv
// tb_cmd_proc: directed plus randomized checks of cmd_proc against a command-level model.
module tb_cmd_proc;

  logic        clk;
  logic        rst_n;
  logic        cmd_rdy;
  logic [15:0] cmd;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        resp_sent;
  logic        strt_cal;
  logic        cal_done;
  logic        sq_done;
  logic        moving;
  logic [7:0]  heading;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_regs [4];
  logic [7:0] model_heading;

  cmd_proc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_rdy    (cmd_rdy),
    .cmd        (cmd),
    .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp  (send_resp),
    .resp       (resp),
    .resp_sent  (resp_sent),
    .strt_cal   (strt_cal),
    .cal_done   (cal_done),
    .sq_done    (sq_done),
    .moving     (moving),
    .heading    (heading),
    .busy       (busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {7'd0, observed}, {7'd0, expected});
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
    model_heading = 8'h00;
  endfunction

  // Command-level model: applies the command's effect and returns its response byte.
  function automatic logic [7:0] modelExecute(input logic [15:0] c);
    logic [7:0] r;
    case (c[15:12])
      4'h0, 4'h2: r = 8'hA5;
      4'h4: begin
        model_heading = c[11:4];
        r = 8'hA5;
      end
      4'h8: begin
        model_regs[c[9:8]] = c[7:0];
        r = 8'hA5;
      end
      4'h9: r = model_regs[c[9:8]];
      default: r = 8'h5A;
    endcase
    return r;
  endfunction

  // Offer a command and return in the cycle after it was captured.
  task automatic applyStimulus(input logic [15:0] c);
    int waited;
    waited = 0;
    tick();
    cmd = c;
    cmd_rdy = 1'b1;
    #1;
    while (!clr_cmd_rdy && waited < 20) begin
      tick();
      #1;
      waited++;
    end
    checkBit("clr_cmd_rdy ack", clr_cmd_rdy, 1'b1);
    tick();
    checkBit("clr_cmd_rdy one cycle", clr_cmd_rdy, 1'b0);
    cmd_rdy = 1'b0;
    cmd = 16'($urandom);
  endtask

  // Called in the cycle send_resp should be high; completes the handshake.
  task automatic finishResp(input logic [7:0] exp_resp, input int hold);
    checkBit("send_resp", send_resp, 1'b1);
    checkOutput("resp value", resp, exp_resp);
    for (int i = 0; i < hold; i++) begin
      tick();
      checkBit("send_resp single", send_resp, 1'b0);
      checkOutput("resp stable", resp, exp_resp);
      checkBit("busy waiting", busy, 1'b1);
    end
    resp_sent = 1'b1;
    tick();
    resp_sent = 1'b0;
    checkBit("busy after sent", busy, 1'b0);
    checkOutput("heading hold", heading, model_heading);
  endtask

  task automatic runCmd(input logic [15:0] c, input int cal_wait);
    logic [7:0] exp_resp;
    int n;
    int gap;
    exp_resp = modelExecute(c);
    n = int'(c[3:0]);
    applyStimulus(c);
    tick();
    if (c[15:12] == 4'h2) begin
      checkBit("strt_cal pulse", strt_cal, 1'b1);
      for (int i = 0; i < cal_wait; i++) begin
        sq_done = 1'($urandom_range(0, 1));
        tick();
        checkBit("strt_cal single", strt_cal, 1'b0);
        checkBit("no send_resp in CAL", send_resp, 1'b0);
        checkBit("busy in CAL", busy, 1'b1);
      end
      sq_done = 1'b0;
      cal_done = 1'b1;
      tick();
      cal_done = 1'b0;
    end else if (c[15:12] == 4'h4 && n != 0) begin
      checkBit("moving in MOVE", moving, 1'b1);
      checkOutput("heading loaded", heading, c[11:4]);
      for (int s = 0; s < n; s++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          cal_done = 1'b1;
          tick();
          cal_done = 1'b0;
          checkBit("moving held", moving, 1'b1);
          checkBit("no send_resp in MOVE", send_resp, 1'b0);
        end
        sq_done = 1'b1;
        tick();
        sq_done = 1'b0;
        if (s < n - 1) checkBit("moving until last square", moving, 1'b1);
        else checkBit("moving drops", moving, 1'b0);
      end
    end else begin
      checkBit("moving never", moving, 1'b0);
    end
    finishResp(exp_resp, $urandom_range(1, 3));
  endtask

  logic [3:0] illegal_ops [11] = '{4'h1, 4'h3, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  // Directed sequence followed by randomized commands
  initial begin
    logic [7:0]  exp_resp;
    logic [15:0] rc;

    cmd_rdy = 1'b0;
    cmd = 16'h0000;
    resp_sent = 1'b0;
    cal_done = 1'b0;
    sq_done = 1'b0;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    modelReset();
    #2;
    checkBit("reset busy", busy, 1'b0);
    checkBit("reset moving", moving, 1'b0);
    checkBit("reset send_resp", send_resp, 1'b0);
    checkBit("reset strt_cal", strt_cal, 1'b0);
    checkBit("reset clr_cmd_rdy", clr_cmd_rdy, 1'b0);
    checkOutput("reset resp", resp, 8'h00);
    checkOutput("reset heading", heading, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;

    $display("[TB] directed commands");
    runCmd(16'h0000, 0);
    runCmd(16'h9100, 0);
    runCmd(16'h82C3, 0);
    runCmd(16'h9200, 0);
    runCmd(16'h45A3, 0);
    runCmd(16'h4000, 0);
    runCmd(16'h2000, 50);

    $display("[TB] illegal command with overlapping cmd_rdy");
    exp_resp = modelExecute(16'hF123);
    applyStimulus(16'hF123);
    tick();
    checkBit("illegal send_resp", send_resp, 1'b1);
    checkOutput("illegal resp", resp, exp_resp);
    tick();
    cmd = 16'h0000;
    cmd_rdy = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkBit("no clr in WAIT_SENT", clr_cmd_rdy, 1'b0);
      tick();
    end
    resp_sent = 1'b1;
    tick();
    resp_sent = 1'b0;
    checkBit("pending cmd serviced", clr_cmd_rdy, 1'b1);
    exp_resp = modelExecute(16'h0000);
    tick();
    checkBit("pending clr one cycle", clr_cmd_rdy, 1'b0);
    cmd_rdy = 1'b0;
    tick();
    finishResp(exp_resp, 1);

    $display("[TB] reset in the middle of MOVE");
    exp_resp = modelExecute(16'h4123);
    applyStimulus(16'h4123);
    tick();
    checkBit("move before reset", moving, 1'b1);
    sq_done = 1'b1;
    tick();
    sq_done = 1'b0;
    checkBit("move after one square", moving, 1'b1);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkBit("mid-move reset moving", moving, 1'b0);
    checkOutput("mid-move reset heading", heading, 8'h00);
    checkBit("mid-move reset busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkBit("no send_resp after reset", send_resp, 1'b0);
    end
    runCmd(16'h0000, 0);
    runCmd(16'h9200, 0);

    $display("[TB] randomized commands");
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: rc = {4'h0, 12'($urandom)};
        1: rc = {4'h2, 12'($urandom)};
        2: rc = {4'h4, 8'($urandom), 4'($urandom_range(0, 4))};
        3: rc = {4'h8, 12'($urandom)};
        4: rc = {4'h9, 12'($urandom)};
        default: rc = {illegal_ops[$urandom_range(0, 10)], 12'($urandom)};
      endcase
      runCmd(rc, $urandom_range(1, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_proc.md
CMD_PROC -- requirements
Module: cmd_proc

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk rises-edge clock, rst_n async active-low reset; all flops clear on rst_n low regardless of clk.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_rdy  in  1  16-bit command available from the UART wrapper
- cmd  in  16  command word, valid while cmd_rdy=1
- clr_cmd_rdy  out  1  one-cycle acknowledge of cmd consumption
- send_resp  out  1  one-cycle request to transmit resp
- resp  out  8  response byte
- resp_sent  in  1  wrapper finished transmitting resp (pulse)
- strt_cal  out  1  one-cycle calibration start
- cal_done  in  1  calibration complete (pulse)
- sq_done  in  1  one square of motion complete (pulse)
- moving  out  1  motion in progress
- heading  out  8  commanded heading
- busy  out  1  high whenever state != IDLE

Function
REQ-003 Opcode SHALL be cmd[15:12]: 0x0 NOP, 0x2 CAL, 0x4 MOVE (cmd[11:4] heading, cmd[3:0] squares), 0x8 WRITE (cmd[9:8] addr, cmd[7:0] data), 0x9 READ (cmd[9:8] addr); all other opcodes ILLEGAL.
REQ-004 FSM states SHALL be IDLE, EXEC, CAL, MOVE, RESP, WAIT_SENT.
REQ-005 In IDLE with cmd_rdy=1, the block SHALL drive clr_cmd_rdy=1 combinationally for that cycle only, latch cmd into cmd_q at the edge, and go to EXEC.
REQ-006 clr_cmd_rdy SHALL be 0 in every state except IDLE; cmd_rdy outside IDLE SHALL be ignored, not cleared, and SHALL be serviced on the next IDLE cycle.
REQ-007 EXEC (one cycle) SHALL act as follows:
- NOP: resp<=0xA5 -> RESP
- WRITE: reg[addr]<=data, resp<=0xA5 -> RESP
- READ: resp<=reg[addr] -> RESP
- ILLEGAL: resp<=0x5A -> RESP
- CAL: strt_cal pulse -> CAL
- MOVE: heading<=cmd_q[11:4], sq_cnt<=cmd_q[3:0] -> MOVE, or -> RESP with resp<=0xA5 if squares=0
REQ-008 strt_cal SHALL be a registered pulse, high exactly the first cycle of CAL; CAL SHALL hold until cal_done=1, then load resp<=0xA5 and go to RESP.
REQ-009 moving SHALL be registered high for exactly the cycles in MOVE; each sq_done decrements the 4-bit sq_cnt; sq_done with sq_cnt=1 SHALL load resp<=0xA5 and go to RESP.
REQ-010 sq_done outside MOVE and cal_done outside CAL SHALL be ignored.
REQ-011 RESP SHALL assert send_resp for exactly one cycle, then go to WAIT_SENT.
REQ-012 resp SHALL remain stable from send_resp until resp_sent; WAIT_SENT SHALL go to IDLE on resp_sent=1.
REQ-013 heading SHALL hold its last loaded value outside MOVE.
REQ-014 Register file SHALL be 4x8; it is observable only via READ.
REQ-015 Latency for NOP/WRITE/READ/ILLEGAL: send_resp SHALL be high in the second cycle after the edge capturing cmd.

Reset
REQ-016 On rst_n=0 the block SHALL immediately force IDLE, and SHALL clear clr_cmd_rdy (except its combinational term), send_resp, strt_cal, moving, busy to 0; resp, heading, sq_cnt, cmd_q and all four registers to 0x00.
REQ-017 Reset mid-CAL/MOVE/WAIT_SENT SHALL abandon the command with no response; the first post-reset cmd_rdy SHALL be processed normally.

Verification
REQ-018 NOP: cmd=0x0000, cmd_rdy -> clr_cmd_rdy 1 cycle, send_resp 2 cycles later, resp=0xA5; resp_sent -> IDLE, busy=0.
REQ-019 WRITE/READ: 0x82C3 then 0x9200 -> second resp=0xC3; READ 0x9100 after reset -> resp=0x00.
REQ-020 MOVE: cmd=0x45A3 -> heading=0x5A, moving=1; after 3 sq_done pulses send_resp with resp=0xA5; 0x4000 -> immediate 0xA5, moving never high.
REQ-021 CAL: cmd=0x2000 -> strt_cal single pulse; hold cal_done low 50 cycles (busy=1, no send_resp); cal_done -> resp=0xA5.
REQ-022 ILLEGAL/overlap: cmd=0xF123 -> resp=0x5A; assert cmd_rdy during WAIT_SENT -> no clr_cmd_rdy until resp_sent, then serviced.
REQ-023 Reset mid-MOVE: rst_n low after 1 sq_done -> moving=0, heading=0x00, no send_resp; next NOP returns 0xA5.
